// File: rtl/add16_pipe_pkg.sv
// Shared sizing for the pipelined adder: operand width, slice width and the
// stage count derived from them, plus the signed-overflow rule.
package add_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SLICE = 4;
  localparam int unsigned N     = WIDTH / SLICE;

  // Two's-complement overflow from the operand signs and the result sign.
  function automatic logic ovf_of(input logic sign_a, input logic sign_b,
                                  input logic sign_s);
    return (sign_a == sign_b) && (sign_s != sign_a);
  endfunction

endpackage

// File: rtl/add16_pipe_cla_slice.sv
// Combinational carry-lookahead slice: W-bit a + b + ci -> s, co.
module cla_slice
  import add_pkg::*;
#(
  parameter int unsigned W = SLICE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the OR of generate terms propagated up to bit i, plus ci
  // propagated through every lower bit, so no carry ripples through another.
  always_comb begin
    logic term;
    term = 1'b0;
    c    = '0;
    c[0] = ci;
    for (int unsigned i = 1; i <= W; i++) begin
      term = ci;
      for (int unsigned m = 0; m < i; m++) begin
        term = term & p[m];
      end
      c[i] = term;
      for (int unsigned j = 0; j < i; j++) begin
        term = g[j];
        for (int unsigned m = j + 1; m < i; m++) begin
          term = term & p[m];
        end
        c[i] = c[i] | term;
      end
    end
  end

  assign s  = p ^ c[W-1:0];
  assign co = c[W];

endmodule

// File: rtl/add16_pipe.sv
// Pipelined adder: one lookahead slice per stage, valid/ready handshake on
// both sides, elastic stalls with no bubbles, results in acceptance order.
module add16_pipe #(
  parameter int unsigned WIDTH = add_pkg::WIDTH,
  parameter int unsigned SLICE = add_pkg::SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned N = WIDTH / SLICE;

  import add_pkg::*;

  // Per-stage state: valid, carry into the next slice, completed low sum
  // bits, operand bits not yet consumed (shifted down), and operand signs.
  logic [N-1:0]     valid_q;
  logic [N-1:0]     carry_q;
  logic [N-1:0]     sa_q;
  logic [N-1:0]     sb_q;
  logic [WIDTH-1:0] sum_q   [N];
  logic [WIDTH-1:0] a_rem_q [N];
  logic [WIDTH-1:0] b_rem_q [N];

  logic [N-1:0]     adv;
  logic [N-1:0]     en;
  logic [WIDTH-1:0] slice_s;
  logic [N-1:0]     slice_co;

  // Stage k may move on when the stage after it is empty or moving on; a
  // stage can load whenever it is empty or its contents are leaving.
  always_comb begin
    adv      = '0;
    en       = '0;
    adv[N-1] = out_ready;
    for (int unsigned i = 0; i + 1 < N; i++) begin
      adv[N-2-i] = !valid_q[N-1-i] || adv[N-1-i];
    end
    for (int unsigned k = 0; k < N; k++) begin
      en[k] = !valid_q[k] || adv[k];
    end
  end

  assign in_ready = en[0];

  generate
    for (genvar k = 0; k < N; k++) begin : g_slice
      logic [SLICE-1:0] op_a;
      logic [SLICE-1:0] op_b;
      logic             op_ci;

      if (k == 0) begin : g_first
        assign op_a  = a[SLICE-1:0];
        assign op_b  = b[SLICE-1:0];
        assign op_ci = c_in;
      end else begin : g_rest
        assign op_a  = a_rem_q[k-1][SLICE-1:0];
        assign op_b  = b_rem_q[k-1][SLICE-1:0];
        assign op_ci = carry_q[k-1];
      end

      cla_slice #(
        .W(SLICE)
      ) u_cla (
        .a (op_a),
        .b (op_b),
        .ci(op_ci),
        .s (slice_s[k*SLICE +: SLICE]),
        .co(slice_co[k])
      );
    end
  endgenerate

  // Pipeline registers: payload only loads alongside a valid item, so a
  // bubble moving through leaves the old payload in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        sum_q[k]   <= '0;
        a_rem_q[k] <= '0;
        b_rem_q[k] <= '0;
      end
    end else begin
      if (en[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          carry_q[0] <= slice_co[0];
          sa_q[0]    <= a[WIDTH-1];
          sb_q[0]    <= b[WIDTH-1];
          sum_q[0]   <= WIDTH'(slice_s[SLICE-1:0]);
          a_rem_q[0] <= a >> SLICE;
          b_rem_q[0] <= b >> SLICE;
        end
      end
      for (int unsigned k = 1; k < N; k++) begin
        if (en[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            carry_q[k]                 <= slice_co[k];
            sa_q[k]                    <= sa_q[k-1];
            sb_q[k]                    <= sb_q[k-1];
            sum_q[k]                   <= sum_q[k-1];
            sum_q[k][k*SLICE +: SLICE] <= slice_s[k*SLICE +: SLICE];
            a_rem_q[k]                 <= a_rem_q[k-1] >> SLICE;
            b_rem_q[k]                 <= b_rem_q[k-1] >> SLICE;
          end
        end
      end
    end
  end

  assign out_valid = valid_q[N-1];
  assign sum       = sum_q[N-1];
  assign c_out     = carry_q[N-1];
  assign ovf       = ovf_of(sa_q[N-1], sb_q[N-1], sum_q[N-1][WIDTH-1]);

endmodule

// File: tb/tb_add16_pipe.sv
// Directed and randomised checks for add16_pipe with an in-order expected queue.
module tb_add16_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  vec_t tbl [17];
  exp_t expq [$];
  int   in_cyc [$];
  int   out_cyc [$];
  int   cyc;
  int   n_checks;
  int   n_errors;

  add16_pipe #(
    .WIDTH(16),
    .SLICE(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [15:0] va,
                         input logic [15:0] vb, input logic vci,
                         input logic [15:0] vs, input logic vc,
                         input logic vo);
    tbl[i].a  = va;
    tbl[i].b  = vb;
    tbl[i].ci = vci;
    tbl[i].s  = vs;
    tbl[i].c  = vc;
    tbl[i].o  = vo;
  endtask

  // Output monitor: every downstream transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("sum", 32'(sum), 32'(e.s));
        check("c_out", 32'(c_out), 32'(e.c));
        check("ovf", 32'(ovf), 32'(e.o));
      end
      out_cyc.push_back(cyc);
    end
  end

  // Offer table entries first..first+count-1 for exactly 'cycles' cycles.
  task automatic offer(input int first, input int count, input int cycles,
                       output int acc);
    acc = 0;
    for (int c = 0; c < cycles; c++) begin
      if (acc < count) begin
        in_valid = 1'b1;
        a        = tbl[first+acc].a;
        b        = tbl[first+acc].b;
        c_in     = tbl[first+acc].ci;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        expq.push_back('{s: tbl[first+acc].s, c: tbl[first+acc].c,
                         o: tbl[first+acc].o});
        in_cyc.push_back(cyc);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc_r;
    int cyc_r;
    logic [16:0] t;

    cyc      = 0;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a        = '0;
    b        = '0;
    c_in     = 1'b0;

    set_vec(0,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    set_vec(1,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    set_vec(2,  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    set_vec(3,  16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    set_vec(4,  16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0);
    set_vec(5,  16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    set_vec(6,  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    set_vec(7,  16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
    set_vec(8,  16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1);
    set_vec(9,  16'hFFFE, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0);
    set_vec(10, 16'h8001, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0);
    set_vec(11, 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0);
    set_vec(12, 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    set_vec(13, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    set_vec(14, 16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0);
    set_vec(15, 16'h0005, 16'h0006, 1'b1, 16'h000C, 1'b0, 1'b0);
    set_vec(16, 16'h0123, 16'h0456, 1'b1, 16'h057A, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Single op: carry out of the top slice, latency of four cycles
    in_cyc.delete();
    out_cyc.delete();
    offer(0, 1, 1, acc);
    wait_drain();
    check("lat_count", 32'(out_cyc.size()), 32'd1);
    if (out_cyc.size() >= 1 && in_cyc.size() >= 1)
      check("latency", 32'(out_cyc[0] - in_cyc[0]), 32'd4);

    // Signed overflow cases
    offer(1, 2, 4, acc);
    check("acc_ovf_ops", 32'(acc), 32'd2);
    wait_drain();

    // Back-to-back stream: four accepts in four cycles, four results in a row
    in_cyc.delete();
    out_cyc.delete();
    offer(3, 4, 4, acc);
    check("acc_stream", 32'(acc), 32'd4);
    wait_drain();
    check("stream_count", 32'(out_cyc.size()), 32'd4);
    for (int i = 1; i < out_cyc.size(); i++)
      check("stream_gap", 32'(out_cyc[i] - out_cyc[i-1]), 32'd1);

    // Stall: only four of six ops fit, output holds the first result
    out_ready = 1'b0;
    offer(7, 6, 8, acc);
    check("acc_stall", 32'(acc), 32'd4);
    check("in_ready_full", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'h0003);
      check("hold_c_out", 32'(c_out), 32'd0);
      check("hold_ovf", 32'(ovf), 32'd0);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    offer(11, 2, 6, acc);
    check("acc_after_stall", 32'(acc), 32'd2);
    wait_drain();

    // Reset with three ops in flight, the oldest already at the output
    out_ready = 1'b0;
    offer(13, 3, 4, acc);
    check("acc_pre_rst", 32'(acc), 32'd3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_sum", 32'(sum), 32'd0);
    expq.delete();
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst2", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    repeat (10) begin
      @(negedge clk);
      check("no_stale_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    in_cyc.delete();
    out_cyc.delete();
    offer(16, 1, 1, acc);
    wait_drain();
    check("lat_count_rst", 32'(out_cyc.size()), 32'd1);
    if (out_cyc.size() >= 1 && in_cyc.size() >= 1)
      check("latency_rst", 32'(out_cyc[0] - in_cyc[0]), 32'd4);

    // Random valid/stall traffic against an arithmetic reference
    acc_r = 0;
    cyc_r = 0;
    while (acc_r < 10000 && cyc_r < 60000) begin
      out_ready = ($urandom_range(9) < 7);
      if (!in_valid && ($urandom_range(9) < 7)) begin
        in_valid = 1'b1;
        a        = 16'($urandom);
        b        = 16'($urandom);
        c_in     = 1'($urandom_range(1));
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        t = {1'b0, a} + {1'b0, b} + {16'b0, c_in};
        expq.push_back('{s: t[15:0], c: t[16],
                         o: (a[15] == b[15]) && (t[15] != a[15])});
        acc_r++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      cyc_r++;
    end
    check("rand_accepted", 32'(acc_r), 32'd10000);
    out_ready = 1'b1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/add16_pipe.md
ADD16_PIPE -- requirements
Module: add16_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits. It SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 4: bits added per pipeline stage by one carry-lookahead slice.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; it SHALL be asynchronous and active-low.
REQ-005 in_valid  input  1  upstream offers an operand set this cycle.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 c_in  input  1  carry-in.
REQ-010 out_valid  output  1  sum, c_out and ovf are valid this cycle.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 sum  output  WIDTH  result, A+B+c_in modulo 2^WIDTH.
REQ-013 c_out  output  1  unsigned carry-out.
REQ-014 ovf  output  1  two's-complement overflow.

Function
REQ-015 The block SHALL have N = WIDTH/SLICE pipeline stages; stage k SHALL add bits [k*SLICE+SLICE-1 : k*SLICE] with generate/propagate lookahead, using the registered carry from stage k-1 (c_in for stage 0).
REQ-016 Each stage register SHALL hold: valid bit, carry, low sum bits completed so far, unconsumed upper A/B bits, and the sign bits of A and B for ovf.
REQ-017 Handshakes: a transfer SHALL occur on a cycle where valid and ready are both high; in_valid/a/b/c_in are sampled only on transfer.
REQ-018 Stage k SHALL advance when stage k+1 is empty or advancing; the last stage SHALL advance when out_ready is high. in_ready SHALL be !valid[0] or advance[0] (combinational, no dependency on in_valid).
REQ-019 Latency SHALL be N cycles from the input transfer to out_valid high. Throughput SHALL be one result per cycle while out_ready stays high.
REQ-020 Stall: with out_ready low, out_valid, sum, c_out and ovf SHALL hold steady. Up to N results SHALL buffer without loss. in_ready SHALL fall only when all N stages are valid.
REQ-021 Simultaneous accept and drain on a full pipe SHALL proceed without a bubble.
REQ-022 c_out SHALL be the carry out of the top slice. ovf SHALL be (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
REQ-023 Results SHALL leave in acceptance order. No result SHALL be dropped or duplicated.
REQ-024 out_valid SHALL be a registered signal with no combinational path from in_valid.

Reset
REQ-025 On rst_n low, all valid bits SHALL clear immediately, so out_valid=0. sum, c_out and ovf SHALL read 0.
REQ-026 Reset mid-operation SHALL discard every in-flight result. After release, the first out_valid SHALL appear no earlier than N cycles after the first new transfer.
REQ-027 in_ready SHALL be high in the first cycle after rst_n deasserts.

Structure
REQ-028 Package add_pkg SHALL hold WIDTH, SLICE and the derived stage count N.
REQ-029 Sub-module cla_slice (combinational SLICE-bit lookahead: a, b, ci -> s, co) SHALL be instantiated once per stage through a generate loop. Pipeline registers and handshake logic SHALL live in add16_pipe.

Verification
REQ-030 a=0xFFFF, b=0x0001, c_in=0, out_ready=1 -> exactly 4 cycles later out_valid=1, sum=0x0000, c_out=1, ovf=0.
REQ-031 a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1. a=0x8000, b=0x8000 -> sum=0x0000, c_out=1, ovf=1.
REQ-032 Stream 4 back-to-back ops (0x1234+0x1111, 0x00FF+0x0001 c_in=1, 0xAAAA+0x5555, 0xFFFF+0xFFFF c_in=1) with out_ready=1 -> consecutive results 0x2345, 0x0101, 0xFFFF/c0, 0xFFFF/c1, in order, no gaps.
REQ-033 Hold out_ready=0 and offer 6 ops -> in_ready falls after 4 accepts and outputs hold stable. Release out_ready -> all 4 results emerge in order, and the remaining 2 are then accepted.
REQ-034 Assert rst_n=0 with 3 ops in flight -> out_valid=0 at once. No stale result ever appears after release.
REQ-035 Random stall/valid traffic, 10^4 ops -> every result matches a+b+c_in, with a reference-model scoreboard.
